// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command path: frame control field width,
// command encoding and an address-width helper.
package spi_pkg;

  localparam int CTRL_WIDTH = 2;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_cmd_t;

  // Keeps a single-word memory from collapsing to a zero-width address.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// 1W/1R synchronous RAM with a registered read port; the array and read
// register are never reset so contents survive a controller reset.
module spi_ram_mem
  import spi_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  parameter int AW    = addr_bits(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder behind the SPI slave: edge-detects frame-ready, executes
// address/data commands against the RAM and presents read data back.
module spi_ram_ctrl
  import spi_pkg::*;
#(
  parameter int FRAME_WIDTH = 8,
  parameter int MEM_DEPTH   = 256,
  parameter bit AUTO_INC    = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx_valid,
  input  logic [FRAME_WIDTH+CTRL_WIDTH-1:0] rx_data,
  output logic                            tx_valid,
  output logic [FRAME_WIDTH-1:0]          tx_data,
  output logic                            cmd_err
);

  localparam int AW = addr_bits(MEM_DEPTH);

  logic                   rx_valid_q, init_q;
  logic                   accept;
  spi_cmd_t               cmd;
  logic [FRAME_WIDTH-1:0] payload;
  logic [AW-1:0]          wr_addr_q, wr_addr_d;
  logic [AW-1:0]          rd_addr_q, rd_addr_d;
  logic                   rd_addr_set_q, rd_addr_set_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   cmd_err_q, cmd_err_d;
  logic                   data_ok_q, data_ok_d;
  logic                   mem_we, mem_re;
  logic [FRAME_WIDTH-1:0] mem_rdata;

  // init_q masks the first cycle after reset so a level already high at
  // release is not mistaken for a fresh frame.
  assign accept  = rx_valid & ~rx_valid_q & ~init_q;
  assign cmd     = spi_cmd_t'(rx_data[FRAME_WIDTH+CTRL_WIDTH-1 -: CTRL_WIDTH]);
  assign payload = rx_data[FRAME_WIDTH-1:0];
  assign mem_we  = accept && (cmd == WR_DATA);
  assign mem_re  = accept && (cmd == RD_DATA);

  always_comb begin
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    rd_addr_set_d = rd_addr_set_q;
    tx_valid_d    = tx_valid_q;
    cmd_err_d     = 1'b0;
    data_ok_d     = data_ok_q | mem_re;
    if (!rx_valid) tx_valid_d = 1'b0;
    if (accept) begin
      tx_valid_d = 1'b0;
      unique case (cmd)
        WR_ADDR: wr_addr_d = payload[AW-1:0];
        WR_DATA: begin
          if (AUTO_INC) begin
            if (wr_addr_q == AW'(MEM_DEPTH-1)) wr_addr_d = '0;
            else                               wr_addr_d = wr_addr_q + AW'(1);
          end
        end
        RD_ADDR: begin
          rd_addr_d     = payload[AW-1:0];
          rd_addr_set_d = 1'b1;
        end
        RD_DATA: begin
          tx_valid_d = 1'b1;
          cmd_err_d  = ~rd_addr_set_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_q    <= 1'b0;
      init_q        <= 1'b1;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      rd_addr_set_q <= 1'b0;
      tx_valid_q    <= 1'b0;
      cmd_err_q     <= 1'b0;
      data_ok_q     <= 1'b0;
    end else begin
      rx_valid_q    <= rx_valid;
      init_q        <= 1'b0;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      rd_addr_set_q <= rd_addr_set_d;
      tx_valid_q    <= tx_valid_d;
      cmd_err_q     <= cmd_err_d;
      data_ok_q     <= data_ok_d;
    end
  end

  spi_ram_mem #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (FRAME_WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_addr_q),
    .wdata (payload),
    .re    (mem_re),
    .raddr (rd_addr_q),
    .rdata (mem_rdata)
  );

  // The RAM read register is not reset, so gate it until a read has landed.
  assign tx_valid = tx_valid_q;
  assign tx_data  = data_ok_q ? mem_rdata : '0;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Randomized and directed bench for spi_ram_ctrl; instance 0 has AUTO_INC=0,
// instance 1 has AUTO_INC=1, each checked against a behavioural memory model.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] rxv;
  logic [9:0] rxd [2];
  logic [1:0] txv;
  logic [7:0] txd [2];
  logic [1:0] err;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  logic [7:0] mem_m   [2][256];
  bit         wr_m    [2][256];
  int         wa      [2];
  int         ra      [2];
  bit         rset    [2];
  logic [7:0] last_tx [2];
  bit         lt_known[2];

  always #5 clk = ~clk;

  spi_ram_ctrl #(.FRAME_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1'b0)) dut0 (
    .clk(clk), .rst(rst), .rx_valid(rxv[0]), .rx_data(rxd[0]),
    .tx_valid(txv[0]), .tx_data(txd[0]), .cmd_err(err[0]));

  spi_ram_ctrl #(.FRAME_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1'b1)) dut1 (
    .clk(clk), .rst(rst), .rx_valid(rxv[1]), .rx_data(rxd[1]),
    .tx_valid(txv[1]), .tx_data(txd[1]), .cmd_err(err[1]));

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      wa[s] = 0; ra[s] = 0; rset[s] = 0; last_tx[s] = 8'h00; lt_known[s] = 1;
    end
  endtask

  task automatic model_frame(input int s, input logic [1:0] c, input logic [7:0] p,
                             output logic ev, output logic [7:0] ed, output bit dk,
                             output int eerr);
    ev = 1'b0; eerr = 0;
    case (c)
      2'd0: wa[s] = int'(p);
      2'd1: begin
        mem_m[s][wa[s]] = p; wr_m[s][wa[s]] = 1;
        if (s == 1) wa[s] = (wa[s] + 1) % 256;
      end
      2'd2: begin ra[s] = int'(p); rset[s] = 1; end
      default: begin
        ev = 1'b1; eerr = rset[s] ? 0 : 1;
        last_tx[s] = mem_m[s][ra[s]]; lt_known[s] = wr_m[s][ra[s]];
      end
    endcase
    ed = last_tx[s]; dk = lt_known[s];
  endtask

  // Drives one frame as a level held for 'hold' clocks and reports what was seen.
  task automatic do_frame(input int s, input logic [1:0] c, input logic [7:0] p, input int hold,
                          output logic v0, output logic [7:0] d0, output bit stable,
                          output int errs, output logic va, output logic [7:0] da);
    @(posedge clk); #1;
    rxd[s] = {c, p}; rxv[s] = 1'b1;
    errs = 0; stable = 1; v0 = 1'b0; d0 = 8'h00;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin v0 = txv[s]; d0 = txd[s]; end
      else if (txv[s] !== v0 || txd[s] !== d0) stable = 0;
      if (err[s]) errs++;
    end
    rxv[s] = 1'b0;
    @(posedge clk); #1;
    va = txv[s]; da = txd[s];
    if (err[s]) errs++;
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic v0, va; logic [7:0] d0, da; bit st; int e;
    rst = 1'b1; rxv = 2'b00; rxd[0] = '0; rxd[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_cmp++; if (txv[s] !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid[%0d]: got %b want 0", s, txv[s]); end
      n_cmp++; if (txd[s] !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data[%0d]: got %h want 00", s, txd[s]); end
      n_cmp++; if (err[s] !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_err[%0d]: got %b want 0", s, err[s]); end
    end
    rst = 1'b0;
    model_reset();
    // a non-read frame right after reset must leave the outputs idle
    do_frame(0, 2'd0, 8'h00, 2, v0, d0, st, e, va, da);
    n_cmp++; if (v0 !== 1'b0 || d0 !== 8'h00) begin n_bad++; $display("FAIL post_reset_idle: got v=%b d=%h want v=0 d=00", v0, d0); end
  endtask

  task automatic test_read_before_addr();
    logic v0, va; logic [7:0] d0, da; bit st; int e;
    logic ev; logic [7:0] ed; bit dk; int ee;
    do_frame(0, 2'd0, 8'h00, 1, v0, d0, st, e, va, da); model_frame(0, 2'd0, 8'h00, ev, ed, dk, ee);
    do_frame(0, 2'd1, 8'h5A, 1, v0, d0, st, e, va, da); model_frame(0, 2'd1, 8'h5A, ev, ed, dk, ee);
    do_frame(0, 2'd3, 8'h00, 3, v0, d0, st, e, va, da); model_frame(0, 2'd3, 8'h00, ev, ed, dk, ee);
    n_cmp++; if (v0 !== 1'b1) begin n_bad++; $display("FAIL noaddr_tx_valid: got %b want 1", v0); end
    n_cmp++; if (d0 !== 8'h5A) begin n_bad++; $display("FAIL noaddr_tx_data: got %h want 5a", d0); end
    n_cmp++; if (e !== 1) begin n_bad++; $display("FAIL noaddr_cmd_err_cycles: got %0d want 1", e); end
  endtask

  task automatic test_write_read();
    logic v0, va; logic [7:0] d0, da; bit st; int e;
    logic ev; logic [7:0] ed; bit dk; int ee;
    do_frame(0, 2'd0, 8'h10, 1, v0, d0, st, e, va, da); model_frame(0, 2'd0, 8'h10, ev, ed, dk, ee);
    do_frame(0, 2'd1, 8'hA5, 1, v0, d0, st, e, va, da); model_frame(0, 2'd1, 8'hA5, ev, ed, dk, ee);
    do_frame(0, 2'd2, 8'h10, 1, v0, d0, st, e, va, da); model_frame(0, 2'd2, 8'h10, ev, ed, dk, ee);
    do_frame(0, 2'd3, 8'h00, 6, v0, d0, st, e, va, da); model_frame(0, 2'd3, 8'h00, ev, ed, dk, ee);
    n_cmp++; if (v0 !== 1'b1 || d0 !== 8'hA5) begin n_bad++; $display("FAIL wr_rd_first: got v=%b d=%h want v=1 d=a5", v0, d0); end
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL wr_rd_hold: got stable=%b want 1", st); end
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL wr_rd_cmd_err: got %0d want 0", e); end
    n_cmp++; if (va !== 1'b0 || da !== 8'hA5) begin n_bad++; $display("FAIL wr_rd_release: got v=%b d=%h want v=0 d=a5", va, da); end
  endtask

  task automatic test_auto_inc();
    logic v0, va; logic [7:0] d0, da; bit st; int e;
    logic ev; logic [7:0] ed; bit dk; int ee;
    do_frame(1, 2'd0, 8'hFF, 1, v0, d0, st, e, va, da); model_frame(1, 2'd0, 8'hFF, ev, ed, dk, ee);
    do_frame(1, 2'd1, 8'h11, 1, v0, d0, st, e, va, da); model_frame(1, 2'd1, 8'h11, ev, ed, dk, ee);
    do_frame(1, 2'd1, 8'h22, 1, v0, d0, st, e, va, da); model_frame(1, 2'd1, 8'h22, ev, ed, dk, ee);
    do_frame(1, 2'd2, 8'hFF, 1, v0, d0, st, e, va, da); model_frame(1, 2'd2, 8'hFF, ev, ed, dk, ee);
    do_frame(1, 2'd3, 8'h00, 2, v0, d0, st, e, va, da); model_frame(1, 2'd3, 8'h00, ev, ed, dk, ee);
    n_cmp++; if (d0 !== 8'h11) begin n_bad++; $display("FAIL autoinc_ff: got %h want 11", d0); end
    do_frame(1, 2'd2, 8'h00, 1, v0, d0, st, e, va, da); model_frame(1, 2'd2, 8'h00, ev, ed, dk, ee);
    do_frame(1, 2'd3, 8'h00, 2, v0, d0, st, e, va, da); model_frame(1, 2'd3, 8'h00, ev, ed, dk, ee);
    n_cmp++; if (d0 !== 8'h22) begin n_bad++; $display("FAIL autoinc_wrap: got %h want 22", d0); end
  endtask

  task automatic test_level_edge();
    logic v0, va; logic [7:0] d0, da; bit st; int e;
    logic ev; logic [7:0] ed; bit dk; int ee;
    do_frame(0, 2'd0, 8'h41, 1, v0, d0, st, e, va, da); model_frame(0, 2'd0, 8'h41, ev, ed, dk, ee);
    do_frame(0, 2'd1, 8'h00, 1, v0, d0, st, e, va, da); model_frame(0, 2'd1, 8'h00, ev, ed, dk, ee);
    do_frame(0, 2'd0, 8'h40, 1, v0, d0, st, e, va, da); model_frame(0, 2'd0, 8'h40, ev, ed, dk, ee);
    do_frame(0, 2'd1, 8'h3C, 20, v0, d0, st, e, va, da); model_frame(0, 2'd1, 8'h3C, ev, ed, dk, ee);
    do_frame(0, 2'd2, 8'h40, 1, v0, d0, st, e, va, da); model_frame(0, 2'd2, 8'h40, ev, ed, dk, ee);
    do_frame(0, 2'd3, 8'h00, 2, v0, d0, st, e, va, da); model_frame(0, 2'd3, 8'h00, ev, ed, dk, ee);
    n_cmp++; if (d0 !== 8'h3C) begin n_bad++; $display("FAIL level_write: got %h want 3c", d0); end
    // a second write with no new address must land on the same word
    do_frame(0, 2'd1, 8'h99, 1, v0, d0, st, e, va, da); model_frame(0, 2'd1, 8'h99, ev, ed, dk, ee);
    do_frame(0, 2'd2, 8'h41, 1, v0, d0, st, e, va, da); model_frame(0, 2'd2, 8'h41, ev, ed, dk, ee);
    do_frame(0, 2'd3, 8'h00, 1, v0, d0, st, e, va, da); model_frame(0, 2'd3, 8'h00, ev, ed, dk, ee);
    n_cmp++; if (d0 !== 8'h00) begin n_bad++; $display("FAIL level_no_inc_neighbour: got %h want 00", d0); end
    do_frame(0, 2'd2, 8'h40, 1, v0, d0, st, e, va, da); model_frame(0, 2'd2, 8'h40, ev, ed, dk, ee);
    do_frame(0, 2'd3, 8'h00, 1, v0, d0, st, e, va, da); model_frame(0, 2'd3, 8'h00, ev, ed, dk, ee);
    n_cmp++; if (d0 !== 8'h99) begin n_bad++; $display("FAIL level_same_addr: got %h want 99", d0); end
  endtask

  task automatic test_reset_rx_high();
    logic v0, va; logic [7:0] d0, da; bit st; int e;
    logic ev; logic [7:0] ed; bit dk; int ee;
    @(posedge clk); #1;
    rxd[0] = {2'd1, 8'hEE}; rxv[0] = 1'b1;
    pulse_reset();
    repeat (5) @(posedge clk);
    #1 rxv[0] = 1'b0;
    repeat (2) @(posedge clk);
    // address 0 still holds the value written before reset
    do_frame(0, 2'd3, 8'h00, 2, v0, d0, st, e, va, da); model_frame(0, 2'd3, 8'h00, ev, ed, dk, ee);
    n_cmp++; if (d0 !== 8'h5A) begin n_bad++; $display("FAIL rx_high_at_release: got %h want 5a", d0); end
    n_cmp++; if (e !== ee) begin n_bad++; $display("FAIL rx_high_cmd_err: got %0d want %0d", e, ee); end
  endtask

  task automatic test_async_reset_mid();
    logic v0, va; logic [7:0] d0, da; bit st; int e;
    logic ev; logic [7:0] ed; bit dk; int ee;
    do_frame(0, 2'd2, 8'h10, 1, v0, d0, st, e, va, da); model_frame(0, 2'd2, 8'h10, ev, ed, dk, ee);
    @(posedge clk); #1;
    rxd[0] = {2'd3, 8'h00}; rxv[0] = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (txv[0] !== 1'b1 || txd[0] !== 8'hA5) begin n_bad++; $display("FAIL midrst_before: got v=%b d=%h want v=1 d=a5", txv[0], txd[0]); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (txv[0] !== 1'b0 || txd[0] !== 8'h00) begin n_bad++; $display("FAIL midrst_async: got v=%b d=%h want v=0 d=00", txv[0], txd[0]); end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rxv[0] = 1'b0;
    repeat (2) @(posedge clk);
    do_frame(0, 2'd2, 8'h10, 1, v0, d0, st, e, va, da); model_frame(0, 2'd2, 8'h10, ev, ed, dk, ee);
    do_frame(0, 2'd3, 8'h00, 2, v0, d0, st, e, va, da); model_frame(0, 2'd3, 8'h00, ev, ed, dk, ee);
    n_cmp++; if (v0 !== 1'b1 || d0 !== 8'hA5) begin n_bad++; $display("FAIL midrst_retained: got v=%b d=%h want v=1 d=a5", v0, d0); end
  endtask

  task automatic test_random();
    logic v0, va; logic [7:0] d0, da; bit st; int e;
    logic ev; logic [7:0] ed; bit dk; int ee;
    logic [1:0] c; logic [7:0] p; int h;
    for (int n = 0; n < 60; n++) begin
      int s;
      s = n % 2;
      c = 2'($urandom_range(0, 3));
      p = (c == 2'd0 || c == 2'd2) ? 8'($urandom_range(0, 15) + (s == 1 && n % 8 == 1 ? 240 : 0))
                                   : 8'($urandom);
      h = $urandom_range(1, 5);
      do_frame(s, c, p, h, v0, d0, st, e, va, da);
      model_frame(s, c, p, ev, ed, dk, ee);
      n_cmp++; if (v0 !== ev) begin n_bad++; $display("FAIL rand%0d_tx_valid: dut%0d cmd=%0d got %b want %b", n, s, c, v0, ev); end
      if (dk) begin
        n_cmp++; if (d0 !== ed) begin n_bad++; $display("FAIL rand%0d_tx_data: dut%0d cmd=%0d got %h want %h", n, s, c, d0, ed); end
        n_cmp++; if (da !== ed) begin n_bad++; $display("FAIL rand%0d_data_after: dut%0d got %h want %h", n, s, da, ed); end
      end
      n_cmp++; if (e !== ee) begin n_bad++; $display("FAIL rand%0d_cmd_err: dut%0d got %0d want %0d", n, s, e, ee); end
      n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL rand%0d_hold: dut%0d outputs moved while rx_valid high", n, s); end
      n_cmp++; if (va !== 1'b0) begin n_bad++; $display("FAIL rand%0d_release: dut%0d got %b want 0", n, s, va); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_read_before_addr();
    test_write_read();
    test_auto_inc();
    test_level_edge();
    test_reset_rx_high();
    test_async_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
